// File: rtl/mem_arbiter_pkg.sv
// Shared memory-op encodings, requester indices and arbiter state type for the
// data-memory arbiter and everything that talks to it.
package instruction_set;

  localparam int WORD_SIZE = 32;

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam int REQ_CORE = 0;
  localparam int REQ_DMA  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } arb_state_t;

  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == MEM_READ) || (op == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake and memory-port bus of the data-memory arbiter.
// master = requesters plus memory model, slave = the arbiter itself.
interface mem_arbiter_if;
  import instruction_set::*;

  logic [1:0]                 req_valid;
  logic [1:0]                 req_lock;
  logic [1:0][1:0]            req_op;
  logic [1:0][WORD_SIZE-1:0]  req_addr;
  logic [1:0][WORD_SIZE-1:0]  req_wdata;
  logic [1:0]                 req_ready;
  logic [1:0]                 rsp_valid;
  logic [WORD_SIZE-1:0]       rsp_data;
  logic [1:0]                 mem_op;
  logic [WORD_SIZE-1:0]       mem_addr;
  logic [WORD_SIZE-1:0]       mem_wdata;
  logic [WORD_SIZE-1:0]       mem_rdata;
  logic [1:0]                 owner;

  modport master (
    output req_valid, req_lock, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_op, mem_addr, mem_wdata, owner
  );

  modport slave (
    input  req_valid, req_lock, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_op, mem_addr, mem_wdata, owner
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (core / DMA) arbiter in front of the data-memory port with
// round-robin contention and a bounded exclusive lock.
module mem_arbiter
  import instruction_set::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;

  arb_state_t           state_r;
  logic                 last_grant_r;
  logic [CNT_W-1:0]     lock_cnt_r;
  logic [1:0]           owner_r;
  logic [1:0]           rsp_valid_r;
  logic [WORD_SIZE-1:0] rsp_data_r;

  logic [1:0]           grant_s;
  logic                 accept_s;
  logic                 sel_s;
  logic [1:0]           sel_op_s;
  logic                 lock_done_s;

  // Grant selection; held at zero while reset is asserted.
  always_comb begin
    grant_s = 2'b00;
    if (!reset_n) begin
      grant_s = 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid == 2'b11) begin
            grant_s = last_grant_r ? 2'b01 : 2'b10;
          end else begin
            grant_s = bus.req_valid;
          end
        end
        LOCK0:   grant_s = {1'b0, bus.req_valid[REQ_CORE]};
        LOCK1:   grant_s = {bus.req_valid[REQ_DMA], 1'b0};
        default: grant_s = 2'b00;
      endcase
    end
  end

  assign accept_s    = |grant_s;
  assign sel_s       = grant_s[REQ_DMA];
  assign sel_op_s    = bus.req_op[sel_s];
  assign lock_done_s = (lock_cnt_r == CNT_W'(LOCK_MAX - 1));

  // Memory port mirrors the accepted requester; unknown ops are swallowed as NOP.
  always_comb begin
    bus.mem_op    = MEM_NOP;
    bus.mem_addr  = {WORD_SIZE{1'b0}};
    bus.mem_wdata = {WORD_SIZE{1'b0}};
    if (accept_s && is_mem_op(sel_op_s)) begin
      bus.mem_op    = sel_op_s;
      bus.mem_addr  = bus.req_addr[sel_s];
      bus.mem_wdata = bus.req_wdata[sel_s];
    end else begin
      bus.mem_op    = MEM_NOP;
      bus.mem_addr  = {WORD_SIZE{1'b0}};
      bus.mem_wdata = {WORD_SIZE{1'b0}};
    end
  end

  // Lock FSM, round-robin history and registered owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      lock_cnt_r   <= {CNT_W{1'b0}};
      owner_r      <= 2'b00;
    end else begin
      if (accept_s) begin
        last_grant_r <= sel_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
      case (state_r)
        IDLE: begin
          if (accept_s && bus.req_lock[sel_s]) begin
            state_r    <= sel_s ? LOCK1 : LOCK0;
            owner_r    <= grant_s;
            lock_cnt_r <= {CNT_W{1'b0}};
          end else begin
            state_r    <= IDLE;
            owner_r    <= 2'b00;
          end
        end
        LOCK0, LOCK1: begin
          // The final lock cycle still grants, but the lock is dropped regardless.
          if (lock_done_s || (accept_s && !bus.req_lock[sel_s])) begin
            state_r    <= IDLE;
            owner_r    <= 2'b00;
            lock_cnt_r <= {CNT_W{1'b0}};
          end else begin
            lock_cnt_r <= lock_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r    <= IDLE;
          owner_r    <= 2'b00;
          lock_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Read response: data captured at the accepting edge, valid for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= {WORD_SIZE{1'b0}};
    end else if (accept_s && (sel_op_s == MEM_READ)) begin
      rsp_valid_r <= grant_s;
      rsp_data_r  <= bus.mem_rdata;
    end else begin
      rsp_valid_r <= 2'b00;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.owner     = owner_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic for mem_arbiter, checked against
// a lock/round-robin reference model held in plain integers.
module tb_mem_arbiter;
  import instruction_set::*;

  localparam int LOCK_MAX = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model: who holds the lock (-1 none), for how many lock cycles
  int          lock_owner;
  int          lock_age;
  int          last_g;
  logic [1:0]  exp_rsp_valid;
  logic [31:0] exp_rsp_data;

  logic [1:0]  snap_ready, snap_mem_op, snap_owner, snap_rsp_valid;
  logic [31:0] snap_addr, snap_wdata, snap_rsp_data;
  logic [1:0]  ready_hist [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (lock_owner >= 0) return bus.req_valid[lock_owner] ? lock_owner : -1;
    if (bus.req_valid == 2'b11) return 1 - last_g;
    if (bus.req_valid[0]) return 0;
    if (bus.req_valid[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    lock_owner    = -1;
    lock_age      = 0;
    last_g        = 1;
    exp_rsp_valid = 2'b00;
    exp_rsp_data  = 32'd0;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] w);
    bus.req_valid[i] = v;
    bus.req_lock[i]  = l;
    bus.req_op[i]    = op;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = w;
  endtask

  // check the cycle's outputs, then advance the model over the rising edge
  task automatic tick_pre();
    int g;
    logic [1:0] op;
    #1;
    g  = pick();
    op = (g < 0) ? MEM_NOP : bus.req_op[g];
    snap_ready = bus.req_ready;  snap_mem_op = bus.mem_op;  snap_owner = bus.owner;
    snap_addr = bus.mem_addr;    snap_wdata = bus.mem_wdata;
    snap_rsp_valid = bus.rsp_valid;  snap_rsp_data = bus.rsp_data;
    chk("req_ready", bus.req_ready, (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0 && (op == MEM_READ || op == MEM_WRITE)) begin
      chk("mem_op", bus.mem_op, op);
      chk("mem_addr", bus.mem_addr, bus.req_addr[g]);
      chk("mem_wdata", bus.mem_wdata, bus.req_wdata[g]);
    end else begin
      chk("mem_op_nop", bus.mem_op, MEM_NOP);
      if (g < 0) begin
        chk("mem_addr_idle", bus.mem_addr, 32'd0);
        chk("mem_wdata_idle", bus.mem_wdata, 32'd0);
      end
    end
    chk("owner", bus.owner, (lock_owner < 0) ? 32'd0 : (32'd1 << lock_owner));
    chk("rsp_valid", bus.rsp_valid, exp_rsp_valid);
    chk("rsp_data", bus.rsp_data, exp_rsp_data);
    @(posedge clk);
    if (g >= 0 && op == MEM_READ) begin
      exp_rsp_valid = 2'(32'd1 << g);
      exp_rsp_data  = bus.mem_rdata;
    end else begin
      exp_rsp_valid = 2'b00;
    end
    if (lock_owner >= 0) begin
      if (lock_age == LOCK_MAX - 1 || (g == lock_owner && !bus.req_lock[lock_owner]))
        lock_owner = -1;
      else
        lock_age++;
    end else if (g >= 0 && bus.req_lock[g]) begin
      lock_owner = g;
      lock_age   = 0;
    end
    if (g >= 0) last_g = g;
  endtask

  task automatic tick();
    tick_pre();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_req(0, 1'b1, 1'b0, MEM_WRITE, 32'd0, 32'd0);
    set_req(1, 1'b1, 1'b0, MEM_WRITE, 32'd0, 32'd0);
    bus.mem_rdata = 32'd0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", bus.req_ready, 32'd0);
    chk("rst_mem_op", bus.mem_op, MEM_NOP);
    chk("rst_owner", bus.owner, 32'd0);
    chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    set_req(0, 1'b0, 1'b0, MEM_NOP, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, MEM_NOP, 32'd0, 32'd0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // single core read, latency one
    set_req(0, 1'b1, 1'b0, MEM_READ, 32'd5, 32'd0);
    bus.mem_rdata = 32'h3C;
    tick();
    chk("rd_ready", snap_ready, 32'h1);
    chk("rd_mem_op", snap_mem_op, MEM_READ);
    chk("rd_addr", snap_addr, 32'd5);
    set_req(0, 1'b0, 1'b0, MEM_NOP, 32'd0, 32'd0);
    bus.mem_rdata = 32'h77;
    tick();
    chk("rd_rsp_valid", snap_rsp_valid, 32'h1);
    chk("rd_rsp_data", snap_rsp_data, 32'h3C);

    // contention without lock alternates
    do_reset();
    set_req(0, 1'b1, 1'b0, MEM_WRITE, 32'h10, 32'hA0);
    set_req(1, 1'b1, 1'b0, MEM_WRITE, 32'h20, 32'hB1);
    for (int i = 0; i < 4; i++) begin
      tick();
      ready_hist[i] = snap_ready;
      chk("rr_wdata", snap_wdata, (i % 2 == 0) ? 32'hA0 : 32'hB1);
    end
    for (int i = 0; i < 4; i++) chk("rr_ready", ready_hist[i], (i % 2 == 0) ? 32'h1 : 32'h2);

    // held core lock expires after LOCK_MAX lock cycles
    do_reset();
    set_req(0, 1'b1, 1'b1, MEM_WRITE, 32'h11, 32'h1);
    set_req(1, 1'b1, 1'b0, MEM_WRITE, 32'h22, 32'h2);
    for (int i = 0; i < LOCK_MAX + 2; i++) begin
      tick();
      ready_hist[i] = snap_ready;
    end
    for (int i = 0; i < LOCK_MAX + 2; i++)
      chk("lockmax_ready", ready_hist[i], (i <= LOCK_MAX) ? 32'h1 : 32'h2);

    // voluntary unlock hands over to waiting DMA
    do_reset();
    set_req(0, 1'b1, 1'b1, MEM_WRITE, 32'h1, 32'h1);
    set_req(1, 1'b1, 1'b0, MEM_WRITE, 32'h2, 32'h2);
    tick();
    tick();
    chk("lock_owner", snap_owner, 32'h1);
    set_req(0, 1'b1, 1'b0, MEM_WRITE, 32'h1, 32'h1);
    tick();
    tick();
    chk("unlock_ready", snap_ready, 32'h2);
    chk("unlock_owner", snap_owner, 32'h0);

    // unsupported op is consumed silently
    do_reset();
    set_req(0, 1'b1, 1'b0, 2'b11, 32'h9, 32'h9);
    tick();
    chk("badop_ready", snap_ready, 32'h1);
    chk("badop_mem_op", snap_mem_op, MEM_NOP);
    set_req(0, 1'b0, 1'b0, MEM_NOP, 32'd0, 32'd0);
    tick();
    chk("badop_rsp", snap_rsp_valid, 32'h0);

    // asynchronous reset right after a locked DMA read
    do_reset();
    set_req(1, 1'b1, 1'b1, MEM_WRITE, 32'h30, 32'h31);
    tick();
    set_req(1, 1'b1, 1'b1, MEM_READ, 32'h40, 32'h0);
    bus.mem_rdata = 32'h55;
    tick_pre();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_owner", bus.owner, 32'h0);
    chk("arst_mem_op", bus.mem_op, MEM_NOP);
    chk("arst_ready", bus.req_ready, 32'h0);
    chk("arst_rsp_valid", bus.rsp_valid, 32'h0);
    @(posedge clk);
    #1 chk("arst_rsp_hold", bus.rsp_valid, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    set_req(0, 1'b1, 1'b0, MEM_WRITE, 32'h1, 32'h1);
    set_req(1, 1'b1, 1'b0, MEM_WRITE, 32'h2, 32'h2);
    tick();
    chk("arst_first_core", snap_ready, 32'h1);
    chk("arst_no_rsp", snap_rsp_valid, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++)
        set_req(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                2'($urandom_range(0, 3)), $urandom, $urandom);
      bus.mem_rdata = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 8; maximum cycles one requester may hold a lock before forced release.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  2  per-requester access request; index 0 = core, 1 = DMA/loader.
REQ-005 req_lock  in  2  requester asks to keep exclusive grant after this access.
REQ-006 req_op  in  2x2  per-requester op (MEM_READ / MEM_WRITE).
REQ-007 req_addr  in  2xWORD_SIZE  per-requester data-memory address.
REQ-008 req_wdata  in  2xWORD_SIZE  per-requester write data.
REQ-009 req_ready  out  2  one-hot accept strobe; access occurs when valid and ready are both high.
REQ-010 rsp_valid  out  2  one-cycle pulse, read data for that requester on rsp_data.
REQ-011 rsp_data  out  WORD_SIZE  registered read data.
REQ-012 mem_op  out  2  op driven to the data-memory port; MEM_NOP when idle.
REQ-013 mem_addr  out  WORD_SIZE  address driven to the memory port.
REQ-014 mem_wdata  out  WORD_SIZE  write data driven to the memory port.
REQ-015 mem_rdata  in  WORD_SIZE  combinational read data returned by the memory port.
REQ-016 owner  out  2  one-hot current lock owner; 2'b00 when unlocked.

Function
REQ-017 req_ready SHALL be combinational from state and req_valid; at most one bit high; never high without the matching req_valid.
REQ-018 mem_op/mem_addr/mem_wdata SHALL mirror the accepted requester in the same cycle; otherwise mem_op = MEM_NOP, addr/wdata = 0.
REQ-019 Accepted read: mem_rdata captured at that edge into rsp_data; rsp_valid[i] high exactly the next cycle; latency 1.
REQ-020 Accepted write: no response; rsp_data holds its last read value.
REQ-021 Accepted op other than MEM_READ/MEM_WRITE: consumed, mem_op = MEM_NOP, no response.
REQ-022 States IDLE, LOCK0, LOCK1.
REQ-023 IDLE, one valid: grant it.
REQ-024 IDLE, both valid: grant the requester not equal to last_grant (round robin).
REQ-025 last_grant SHALL update on every accept.
REQ-026 LOCKi: only i may be granted; the other's ready SHALL be 0 even if i is not valid.
REQ-027 IDLE -> LOCKi on accept of i with req_lock[i]=1; lock_cnt cleared to 0.
REQ-028 LOCKi -> IDLE on accept of i with req_lock[i]=0.
REQ-029 lock_cnt increments each LOCKi cycle; at lock_cnt = LOCK_MAX-1, next state IDLE regardless of req_lock; that cycle's access is still granted.
REQ-030 lock_cnt width $clog2(LOCK_MAX)+1; no wrap possible.

Reset
REQ-031 reset_n low SHALL immediately force: state IDLE, last_grant = 1 (core wins first contention), lock_cnt 0, rsp_valid 0, rsp_data 0, req_ready 0, mem_op MEM_NOP, owner 0.
REQ-032 Reset mid-lock or mid-read SHALL drop the lock and the pending response; no rsp_valid after release.

Structure
REQ-033 MEM_NOP, REQ_CORE/REQ_DMA index constants and enum arb_state_t SHALL live in package instruction_set; WORD_SIZE taken from it.
REQ-034 Single module, no sub-modules; lives between requesters and memory_manager's op/addr/write_data/read_data port.

Verification
REQ-035 After reset, req_valid=01, READ addr 5, mem_rdata=0x3C -> req_ready=01, mem_op=MEM_READ, mem_addr=5 same cycle; next cycle rsp_valid=01, rsp_data=0x3C.
REQ-036 Both valid, continuous writes, no lock -> grants alternate core, DMA, core, DMA; mem_wdata follows grantee.
REQ-037 Both valid, req_lock=01 held, LOCK_MAX=8 -> core granted 9 consecutive cycles (1 IDLE + 8 LOCK0), then DMA granted.
REQ-038 Core locked, then core access with req_lock[0]=0 while DMA valid -> IDLE next cycle, DMA granted, owner 00.
REQ-039 reset_n pulsed low asynchronously in LOCK1 with read just accepted -> owner 00, mem_op MEM_NOP at once; no rsp_valid; first contention after release goes to core.
REQ-040 Core valid with op not READ/WRITE -> req_ready=01, mem_op=MEM_NOP, rsp_valid stays 00.
